// File: rtl/rtc_time_controller.sv
// Real-time clock sequencer: 1 Hz prescaler, seconds/minutes/hours cascade
// enables, and the user set-mode FSM that loads new values into the counters.
module rtc_time_controller #(
  parameter int CLK_HZ = 50_000_000,
  parameter int HOURS  = 24,
  parameter int PW     = $clog2(CLK_HZ),
  parameter int HW     = $clog2(HOURS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode_btn,
  input  logic          inc_btn,
  input  logic [5:0]    sec_count,
  input  logic [5:0]    min_count,
  input  logic [HW-1:0] hr_count,
  output logic          tick_1hz,
  output logic          en_sec,
  output logic          en_min,
  output logic          en_hr,
  output logic          load_sec,
  output logic          load_min,
  output logic          load_hr,
  output logic [5:0]    load_data_sec,
  output logic [5:0]    load_data_min,
  output logic [HW-1:0] load_data_hr,
  output logic [1:0]    mode
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_t;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [5:0]    MS_MAX    = 6'd59;
  localparam logic [HW-1:0] HR_MAX    = HW'(HOURS - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          load_sec_q, load_sec_d;
  logic          load_min_q, load_min_d;
  logic          load_hr_q, load_hr_d;
  logic [5:0]    load_data_sec_q, load_data_sec_d;
  logic [5:0]    load_data_min_q, load_data_min_d;
  logic [HW-1:0] load_data_hr_q, load_data_hr_d;

  // Set-mode FSM: each mode_btn pulse steps to the next field, wrapping back to RUN.
  always_comb begin
    state_d = state_q;
    if (mode_btn) begin
      case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        SET_SEC: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Prescaler only runs while staying in RUN, so re-entering RUN restarts a full second.
  always_comb begin
    presc_d = '0;
    if (state_q == RUN && state_d == RUN) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end
  end

  // Increment request in a SET state: compute the wrapped value and arm a one-cycle load.
  always_comb begin
    load_sec_d      = 1'b0;
    load_min_d      = 1'b0;
    load_hr_d       = 1'b0;
    load_data_sec_d = load_data_sec_q;
    load_data_min_d = load_data_min_q;
    load_data_hr_d  = load_data_hr_q;
    if (inc_btn && !mode_btn) begin
      case (state_q)
        SET_HR: begin
          load_hr_d      = 1'b1;
          load_data_hr_d = (hr_count >= HR_MAX) ? '0 : hr_count + HW'(1);
        end
        SET_MIN: begin
          load_min_d      = 1'b1;
          load_data_min_d = (min_count >= MS_MAX) ? 6'd0 : min_count + 6'd1;
        end
        SET_SEC: begin
          load_sec_d      = 1'b1;
          load_data_sec_d = (sec_count >= MS_MAX) ? 6'd0 : sec_count + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // State, prescaler and load registers; reset cancels any pending load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= RUN;
      presc_q         <= '0;
      load_sec_q      <= 1'b0;
      load_min_q      <= 1'b0;
      load_hr_q       <= 1'b0;
      load_data_sec_q <= '0;
      load_data_min_q <= '0;
      load_data_hr_q  <= '0;
    end else begin
      state_q         <= state_d;
      presc_q         <= presc_d;
      load_sec_q      <= load_sec_d;
      load_min_q      <= load_min_d;
      load_hr_q       <= load_hr_d;
      load_data_sec_q <= load_data_sec_d;
      load_data_min_q <= load_data_min_d;
      load_data_hr_q  <= load_data_hr_d;
    end
  end

  assign tick_1hz      = (state_q == RUN) && (presc_q == PRESC_MAX);
  assign en_sec        = tick_1hz;
  assign en_min        = tick_1hz && (sec_count == MS_MAX);
  assign en_hr         = en_min && (min_count == MS_MAX);
  assign load_sec      = load_sec_q;
  assign load_min      = load_min_q;
  assign load_hr       = load_hr_q;
  assign load_data_sec = load_data_sec_q;
  assign load_data_min = load_data_min_q;
  assign load_data_hr  = load_data_hr_q;
  assign mode          = state_q;

endmodule

// File: tb/tb_rtc_time_controller.sv
// Testbench for rtc_time_controller: a directed vector table, a few hand-written
// corner sequences, then randomized cycles checked against a behavioural model.
module tb_rtc_time_controller;

  localparam int CLK_HZ = 4;
  localparam int HOURS  = 24;
  localparam int HW     = $clog2(HOURS);

  logic          clk;
  logic          reset;
  logic          mode_btn;
  logic          inc_btn;
  logic [5:0]    sec_count;
  logic [5:0]    min_count;
  logic [HW-1:0] hr_count;
  logic          tick_1hz;
  logic          en_sec;
  logic          en_min;
  logic          en_hr;
  logic          load_sec;
  logic          load_min;
  logic          load_hr;
  logic [5:0]    load_data_sec;
  logic [5:0]    load_data_min;
  logic [HW-1:0] load_data_hr;
  logic [1:0]    mode;

  rtc_time_controller #(.CLK_HZ(CLK_HZ), .HOURS(HOURS)) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .sec_count(sec_count), .min_count(min_count), .hr_count(hr_count),
    .tick_1hz(tick_1hz), .en_sec(en_sec), .en_min(en_min), .en_hr(en_hr),
    .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
    .load_data_sec(load_data_sec), .load_data_min(load_data_min),
    .load_data_hr(load_data_hr), .mode(mode)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst, mb, ib;
    logic [5:0]    sec, min;
    logic [HW-1:0] hr;
    logic          chk;
    logic [1:0]    e_mode;
    logic          e_tick, e_es, e_em, e_eh;
    logic [2:0]    e_load;
    logic [5:0]    e_dsec, e_dmin;
    logic [HW-1:0] e_dhr;
  } vec_t;

  int totalChecks  = 0;
  int passedChecks = 0;

  // Behavioural model: mode number, cycles spent in RUN, which field loads this cycle.
  bit m_valid = 0;
  int m_mode, m_run, m_pend, m_dsec, m_dmin, m_dhr;

  function automatic int wrapInc(input int v, input int mx);
    return (v >= mx) ? 0 : v + 1;
  endfunction

  task automatic checkField(input string name, input int act, input int exp);
    totalChecks++;
    if (act != exp) $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    else passedChecks++;
  endtask

  task automatic modelStep();
    int nm;
    if (reset) begin
      m_valid = 1; m_mode = 0; m_run = 0; m_pend = 0;
      m_dsec = 0; m_dmin = 0; m_dhr = 0;
    end else if (m_valid) begin
      nm = mode_btn ? (m_mode + 1) % 4 : m_mode;
      m_pend = 0;
      if (m_mode != 0 && inc_btn && !mode_btn) begin
        m_pend = m_mode;
        if (m_mode == 1) m_dhr  = wrapInc(int'(hr_count), HOURS - 1);
        if (m_mode == 2) m_dmin = wrapInc(int'(min_count), 59);
        if (m_mode == 3) m_dsec = wrapInc(int'(sec_count), 59);
      end
      m_run  = (m_mode == 0 && nm == 0) ? m_run + 1 : 0;
      m_mode = nm;
    end
  endtask

  task automatic checkOutput();
    int tick;
    if (!m_valid) return;
    tick = (m_mode == 0 && (m_run % CLK_HZ) == CLK_HZ - 1) ? 1 : 0;
    checkField("model mode", int'(mode), m_mode);
    checkField("model tick_1hz", int'(tick_1hz), tick);
    checkField("model en_sec", int'(en_sec), tick);
    checkField("model en_min", int'(en_min), (tick == 1 && sec_count == 6'd59) ? 1 : 0);
    checkField("model en_hr", int'(en_hr),
               (tick == 1 && sec_count == 6'd59 && min_count == 6'd59) ? 1 : 0);
    checkField("model load_hr", int'(load_hr), (m_pend == 1) ? 1 : 0);
    checkField("model load_min", int'(load_min), (m_pend == 2) ? 1 : 0);
    checkField("model load_sec", int'(load_sec), (m_pend == 3) ? 1 : 0);
    checkField("model load_data_hr", int'(load_data_hr), m_dhr);
    checkField("model load_data_min", int'(load_data_min), m_dmin);
    checkField("model load_data_sec", int'(load_data_sec), m_dsec);
  endtask

  // Drive one cycle of inputs and move to the falling edge for sampling.
  task automatic applyStimulus(input logic r, input logic mb, input logic ib,
                               input logic [5:0] s, input logic [5:0] m,
                               input logic [HW-1:0] h);
    reset = r; mode_btn = mb; inc_btn = ib;
    sec_count = s; min_count = m; hr_count = h;
    @(negedge clk);
  endtask

  // Let the DUT take the rising edge and advance the model with the same inputs.
  task automatic finishCycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkRow(input int idx, input vec_t v);
    string p;
    p = $sformatf("row%0d", idx);
    checkField({p, " mode"}, int'(mode), int'(v.e_mode));
    checkField({p, " tick_1hz"}, int'(tick_1hz), int'(v.e_tick));
    checkField({p, " en"}, int'({en_sec, en_min, en_hr}), int'({v.e_es, v.e_em, v.e_eh}));
    checkField({p, " load"}, int'({load_hr, load_min, load_sec}), int'(v.e_load));
    checkField({p, " load_data_sec"}, int'(load_data_sec), int'(v.e_dsec));
    checkField({p, " load_data_min"}, int'(load_data_min), int'(v.e_dmin));
    checkField({p, " load_data_hr"}, int'(load_data_hr), int'(v.e_dhr));
  endtask

  function automatic vec_t mkVec(input logic rst, mb, ib, input int sec, min, hr,
                                 input logic chk, input int md, input logic tk, es, em, eh,
                                 input logic [2:0] ld, input int ds, dm, dh);
    vec_t v;
    v.rst = rst; v.mb = mb; v.ib = ib;
    v.sec = 6'(sec); v.min = 6'(min); v.hr = HW'(hr);
    v.chk = chk; v.e_mode = 2'(md);
    v.e_tick = tk; v.e_es = es; v.e_em = em; v.e_eh = eh;
    v.e_load = ld; v.e_dsec = 6'(ds); v.e_dmin = 6'(dm); v.e_dhr = HW'(dh);
    return v;
  endfunction

  function automatic logic [5:0] pickMs();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 6'd59;
    if (r == 3) return 6'($urandom_range(58, 63));
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic [HW-1:0] pickHr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return HW'(HOURS - 1);
    if (r == 3) return HW'($urandom_range(HOURS - 2, 31));
    return HW'($urandom_range(0, 31));
  endfunction

  vec_t vecs[26];

  initial begin
    // Directed table: inputs for one cycle and the outputs expected in that cycle.
    vecs[0]  = mkVec(1,0,0, 0,0,0,  0, 0, 0,0,0,0, 3'b000, 0,0,0);
    vecs[1]  = mkVec(1,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 0,0,0);
    vecs[2]  = mkVec(0,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 0,0,0);
    vecs[3]  = mkVec(0,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 0,0,0);
    vecs[4]  = mkVec(0,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 0,0,0);
    vecs[5]  = mkVec(0,0,0, 0,0,0,  1, 0, 1,1,0,0, 3'b000, 0,0,0);
    vecs[6]  = mkVec(0,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 0,0,0);
    vecs[7]  = mkVec(0,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 0,0,0);
    vecs[8]  = mkVec(0,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 0,0,0);
    vecs[9]  = mkVec(0,0,0, 59,59,5, 1, 0, 1,1,1,1, 3'b000, 0,0,0);
    vecs[10] = mkVec(0,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 0,0,0);
    vecs[11] = mkVec(0,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 0,0,0);
    vecs[12] = mkVec(0,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 0,0,0);
    vecs[13] = mkVec(0,0,0, 59,10,0, 1, 0, 1,1,1,0, 3'b000, 0,0,0);
    vecs[14] = mkVec(0,1,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 0,0,0);
    vecs[15] = mkVec(0,0,1, 0,0,23, 1, 1, 0,0,0,0, 3'b000, 0,0,0);
    vecs[16] = mkVec(0,0,0, 0,0,0,  1, 1, 0,0,0,0, 3'b100, 0,0,0);
    vecs[17] = mkVec(0,1,0, 0,0,0,  1, 1, 0,0,0,0, 3'b000, 0,0,0);
    vecs[18] = mkVec(0,1,1, 0,30,0, 1, 2, 0,0,0,0, 3'b000, 0,0,0);
    vecs[19] = mkVec(0,0,1, 7,0,0,  1, 3, 0,0,0,0, 3'b000, 0,0,0);
    vecs[20] = mkVec(0,0,0, 0,0,0,  1, 3, 0,0,0,0, 3'b001, 8,0,0);
    vecs[21] = mkVec(0,1,0, 0,0,0,  1, 3, 0,0,0,0, 3'b000, 8,0,0);
    vecs[22] = mkVec(0,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 8,0,0);
    vecs[23] = mkVec(0,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 8,0,0);
    vecs[24] = mkVec(0,0,0, 0,0,0,  1, 0, 0,0,0,0, 3'b000, 8,0,0);
    vecs[25] = mkVec(0,0,0, 0,0,0,  1, 0, 1,1,0,0, 3'b000, 8,0,0);

    reset = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0;
    sec_count = '0; min_count = '0; hr_count = '0;
    #1;

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].mb, vecs[i].ib, vecs[i].sec, vecs[i].min, vecs[i].hr);
      if (vecs[i].chk) begin
        checkRow(i, vecs[i]);
        checkOutput();
      end
      finishCycle();
    end

    // Twenty cycles parked in SET_HR with counts at rollover must raise no enable.
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();
    finishCycle();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1'($urandom_range(0, 1)), 6'd59, 6'd59, HW'(HOURS - 1));
      checkField("set_hr mode", int'(mode), 1);
      checkField("set_hr en", int'({tick_1hz, en_sec, en_min, en_hr}), 0);
      checkOutput();
      finishCycle();
    end

    // Reset sampled together with an increment in SET_MIN cancels the load.
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();
    finishCycle();
    applyStimulus(0, 0, 0, 0, 5, 0);
    checkField("set_min mode", int'(mode), 2);
    checkOutput();
    finishCycle();
    applyStimulus(1, 0, 1, 0, 5, 0);
    checkOutput();
    finishCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 5, 0);
      checkField("reset cancel load", int'({load_hr, load_min, load_sec}), 0);
      checkField("reset cancel data_min", int'(load_data_min), 0);
      checkField("reset cancel mode", int'(mode), 0);
      checkOutput();
      finishCycle();
    end

    // Randomized cycles against the behavioural model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 2) == 0), pickMs(), pickMs(), pickHr());
      checkOutput();
      finishCycle();
    end

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
